seven_seg_scanner: RTL and testbench
====================================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed 7-segment digits (2..8).
REQ-002 Parameter CLKS_PER_DIGIT, default 25000: clocks each digit is driven per slot (>=1).
REQ-003 Parameter BLANK_CLKS, default 250: clocks all anodes are off between slots, for anti-ghosting (>=1).
REQ-004 i_Clk  input  1  single system clock; all logic on rising edge.
REQ-005 i_Rst_L  input  1  reset, asynchronous, active-low.
REQ-006 i_Load  input  1  one-cycle strobe capturing i_Value, i_DP and i_Blank.
REQ-007 i_Value  input  4*NUM_DIGITS  hex digits; digit k = bits [4k+3:4k].
REQ-008 i_DP  input  NUM_DIGITS  per-digit decimal point request.
REQ-009 i_Blank  input  NUM_DIGITS  per-digit force-off mask.
REQ-010 i_LZ_En  input  1  leading-zero suppression enable, sampled live.
REQ-011 o_Binary_Num  output  4  nibble of current digit, to the downstream 7-segment decoder.
REQ-012 o_Seg_EN  output  1  high while in S_SHOW.
REQ-013 o_DP  output  1  decimal point for the current digit, delayed one cycle to match decoder latency.
REQ-014 o_Anode_L  output  NUM_DIGITS  active-low one-hot digit select.
REQ-015 o_Frame_Done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-016 FSM states S_BLANK and S_SHOW; one slot = S_BLANK for BLANK_CLKS cycles, then S_SHOW for CLKS_PER_DIGIT cycles.
REQ-017 Digit index advances 0,1,...,NUM_DIGITS-1 and wraps to 0 on the S_SHOW->S_BLANK transition; frame = NUM_DIGITS slots.
REQ-018 o_Binary_Num carries the current digit nibble for the whole slot, including S_BLANK, so the registered decoder (1-cycle latency) is settled before any anode asserts.
REQ-019 In S_BLANK all o_Anode_L bits are 1; in S_SHOW only bit [index] is 0 unless the digit is suppressed.
REQ-020 Digit suppressed when its i_Blank bit is set in the active copy, or when i_LZ_En=1, the index is >0, and it and all higher digits are zero; digit 0 is never zero-suppressed.
REQ-021 Suppressed digit: S_SHOW timing unchanged, anode stays 1, o_Seg_EN still 1.
REQ-022 i_Load captures inputs into a pending register and sets a pending flag; the active register (which drives display) is not altered mid-frame.
REQ-023 At the frame boundary (last-digit S_SHOW -> digit-0 S_BLANK), if the pending flag is set, pending is copied to active and the flag clears; o_Frame_Done pulses in that same cycle regardless.
REQ-024 Load coincident with boundary: the prior pending contents commit; the new load lands in pending with the flag set, and is displayed from the following frame.
REQ-025 Repeated loads within one frame: last one wins.
REQ-026 Slot counter width = clog2 of max(CLKS_PER_DIGIT, BLANK_CLKS); it reloads to 0 at every state change and never overflows.

Reset
REQ-027 While i_Rst_L=0, asynchronously: state S_BLANK, index 0, counter 0, active and pending registers 0, pending flag 0.
REQ-028 Reset output values: o_Anode_L all 1, o_Binary_Num 0, o_Seg_EN 0, o_DP 0, o_Frame_Done 0.
REQ-029 Reset asserted mid-slot aborts the frame immediately; after release, scanning restarts at digit-0 S_BLANK.

Structure
REQ-030 Shared package holds the state enum (S_BLANK, S_SHOW) and the nibble-width constant (4).
REQ-031 One natural sub-module, scan_timer: counter plus terminal-count flag, parameterized by the slot lengths.

Verification (NUM_DIGITS=4, CLKS_PER_DIGIT=4, BLANK_CLKS=2)
REQ-032 Release reset, no load -> anode low pattern 1110,1101,1011,0111, each low for 4 cycles after 2 blank cycles; o_Frame_Done every 24 cycles.
REQ-033 Load 16'h12AB mid-frame -> digits stay 0 until next o_Frame_Done, then o_Binary_Num = B,A,2,1 for digits 0..3.
REQ-034 Load 16'h0040, i_LZ_En=1 -> digits 3 and 2 never assert an anode; digit 1 shows 4, digit 0 shows 0.
REQ-035 Load 16'h1111, then load 16'h2222 on the boundary cycle -> 1111 shown next frame, 2222 the frame after.
REQ-036 Drop i_Rst_L mid-S_SHOW of digit 2 -> o_Anode_L=1111 with no clock edge; after release, digit 0 is the first shown.
REQ-037 i_Blank=4'b0101 with i_DP=4'b0010 -> digits 0 and 2 dark; o_DP high only during digit 1 slot, one cycle later than o_Binary_Num.

Source files
------------

// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner:
// scan states, nibble width and a counter-width helper.
package seven_seg_scanner_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  // Bits needed to count 0..max(a,b)-1; never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Host-side load bus of the scanner: value/DP/blank capture strobe plus
// the live leading-zero suppression enable.
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  import seven_seg_scanner_pkg::*;

  logic                           i_Load;
  logic [NIBBLE_W*NUM_DIGITS-1:0] i_Value;
  logic [NUM_DIGITS-1:0]          i_DP;
  logic [NUM_DIGITS-1:0]          i_Blank;
  logic                           i_LZ_En;

  modport master (
    output i_Load, i_Value, i_DP, i_Blank, i_LZ_En
  );

  modport slave (
    input i_Load, i_Value, i_DP, i_Blank, i_LZ_En
  );

endinterface

// File: rtl/seven_seg_scanner_scan_timer.sv
// Slot timer: counts the cycles of the current phase (blank or show) and
// flags the last cycle of that phase. The count restarts at every phase
// change, so it never runs past the longer of the two phase lengths.
module scan_timer
  import seven_seg_scanner_pkg::*;
#(
  parameter int CLKS_PER_DIGIT = 25000,
  parameter int BLANK_CLKS     = 250
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Show,
  output logic o_Tc
);

  localparam int CNT_W = cnt_width(CLKS_PER_DIGIT, BLANK_CLKS);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLKS_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CLKS - 1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_last;

  assign w_last = i_Show ? SHOW_LAST : BLANK_LAST;
  assign o_Tc   = (r_count == w_last);

  // Count up within a phase, reload to zero on its last cycle.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_count <= '0;
    end else if (o_Tc) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner. Each digit slot is a blank gap with
// all anodes off followed by a show window with one anode on. The digit
// nibble is presented for the whole slot so a registered decoder has
// settled before its anode lights. New display data is double-buffered
// and only committed at frame boundaries.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLKS_PER_DIGIT = 25000,
  parameter int BLANK_CLKS     = 250
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  seven_seg_scanner_if.slave    i_Host,
  output logic [NIBBLE_W-1:0]   o_Binary_Num,
  output logic                  o_Seg_EN,
  output logic                  o_DP,
  output logic [NUM_DIGITS-1:0] o_Anode_L,
  output logic                  o_Frame_Done
);

  localparam int VAL_W = NIBBLE_W * NUM_DIGITS;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Scan state
  state_t                r_state;
  logic [IDX_W-1:0]      r_index;

  // Active (displayed) and pending (next frame) copies of the host data
  logic [VAL_W-1:0]      r_act_value;
  logic [NUM_DIGITS-1:0] r_act_dp;
  logic [NUM_DIGITS-1:0] r_act_blank;
  logic [VAL_W-1:0]      r_pend_value;
  logic [NUM_DIGITS-1:0] r_pend_dp;
  logic [NUM_DIGITS-1:0] r_pend_blank;
  logic                  r_pend_flag;

  // Registered outputs
  logic [NUM_DIGITS-1:0] r_anode_l;
  logic [NIBBLE_W-1:0]   r_bin;
  logic                  r_seg_en;
  logic                  r_dp;
  logic                  r_frame_done;

  // Next-state view, used so the registered outputs line up with the state
  state_t                w_state_next;
  logic [IDX_W-1:0]      w_index_next;
  logic [VAL_W-1:0]      w_act_value_next;
  logic [NUM_DIGITS-1:0] w_act_dp_next;
  logic [NUM_DIGITS-1:0] w_act_blank_next;
  logic                  w_tc;
  logic                  w_boundary;
  logic [NUM_DIGITS-1:0] w_nib_zero;
  logic                  w_upper_zero;
  logic                  w_suppress;
  logic                  w_show_next;
  logic [NUM_DIGITS-1:0] w_sel_l;
  logic [NIBBLE_W-1:0]   w_bin_next;

  scan_timer #(
    .CLKS_PER_DIGIT(CLKS_PER_DIGIT),
    .BLANK_CLKS    (BLANK_CLKS)
  ) u_timer (
    .i_Clk  (i_Clk),
    .i_Rst_L(i_Rst_L),
    .i_Show (r_state == S_SHOW),
    .o_Tc   (w_tc)
  );

  assign w_boundary = (r_state == S_SHOW) && w_tc && (r_index == LAST_IDX);

  // Next phase, digit index and active data (committed only at a boundary).
  always_comb begin
    w_state_next     = r_state;
    w_index_next     = r_index;
    w_act_value_next = r_act_value;
    w_act_dp_next    = r_act_dp;
    w_act_blank_next = r_act_blank;
    if (w_tc) begin
      if (r_state == S_BLANK) begin
        w_state_next = S_SHOW;
      end else begin
        w_state_next = S_BLANK;
        w_index_next = (r_index == LAST_IDX) ? '0 : r_index + 1'b1;
      end
    end
    if (w_boundary && r_pend_flag) begin
      w_act_value_next = r_pend_value;
      w_act_dp_next    = r_pend_dp;
      w_act_blank_next = r_pend_blank;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib_zero
      assign w_nib_zero[gi] = (w_act_value_next[gi*NIBBLE_W +: NIBBLE_W] == '0);
    end
  endgenerate

  // A digit is a leading zero when it and every higher digit are zero.
  always_comb begin
    w_upper_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(w_index_next) && !w_nib_zero[k]) begin
        w_upper_zero = 1'b0;
      end
    end
  end

  assign w_suppress  = w_act_blank_next[w_index_next] ||
                       (i_Host.i_LZ_En && (w_index_next != '0) && w_upper_zero);
  assign w_show_next = (w_state_next == S_SHOW);
  assign w_bin_next  = w_act_value_next[int'(w_index_next)*NIBBLE_W +: NIBBLE_W];

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
      assign w_sel_l[gi] = ~(w_show_next && (w_index_next == IDX_W'(gi)) && !w_suppress);
    end
  endgenerate

  // Scan FSM with registered display outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state      <= S_BLANK;
      r_index      <= '0;
      r_act_value  <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '0;
      r_anode_l    <= '1;
      r_bin        <= '0;
      r_seg_en     <= 1'b0;
      r_dp         <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_index      <= w_index_next;
      r_act_value  <= w_act_value_next;
      r_act_dp     <= w_act_dp_next;
      r_act_blank  <= w_act_blank_next;
      r_anode_l    <= w_sel_l;
      r_bin        <= w_bin_next;
      r_seg_en     <= w_show_next;
      // DP trails the nibble by one cycle to match the decoder latency.
      r_dp         <= r_act_dp[r_index];
      r_frame_done <= w_boundary;
    end
  end

  // Pending buffer: latest load wins; a load on the boundary cycle stays pending.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_pend_value <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_pend_flag  <= 1'b0;
    end else if (i_Host.i_Load) begin
      r_pend_value <= i_Host.i_Value;
      r_pend_dp    <= i_Host.i_DP;
      r_pend_blank <= i_Host.i_Blank;
      r_pend_flag  <= 1'b1;
    end else if (w_boundary) begin
      r_pend_flag  <= 1'b0;
    end
  end

  assign o_Anode_L    = r_anode_l;
  assign o_Binary_Num = r_bin;
  assign o_Seg_EN     = r_seg_en;
  assign o_DP         = r_dp;
  assign o_Frame_Done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with 4 digits, 4-cycle show and
// 2-cycle blank windows (6-cycle slots, 24-cycle frames).
module tb_seven_seg_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] anode_l;
  logic [3:0] bin_num;
  logic       seg_en;
  logic       dp_out;
  logic       frame_done;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    int          p;
    logic [15:0] v;
    logic [3:0]  dp;
    logic [3:0]  bl;
    logic        lz;
  } ld_t;

  localparam ld_t NO_LD = '{p: -1, v: 16'h0, dp: 4'h0, bl: 4'h0, lz: 1'b0};

  seven_seg_scanner_if #(.NUM_DIGITS(4)) bus ();

  seven_seg_scanner #(
    .NUM_DIGITS    (4),
    .CLKS_PER_DIGIT(4),
    .BLANK_CLKS    (2)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_Host      (bus),
    .o_Binary_Num(bin_num),
    .o_Seg_EN    (seg_en),
    .o_DP        (dp_out),
    .o_Anode_L   (anode_l),
    .o_Frame_Done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: load strobe is dropped just after the edge that captured it.
  task automatic tick();
    @(posedge clk);
    #1 bus.i_Load = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_load(input ld_t l);
    bus.i_Load  = 1'b1;
    bus.i_Value = l.v;
    bus.i_DP    = l.dp;
    bus.i_Blank = l.bl;
    bus.i_LZ_En = l.lz;
  endtask

  // Check one frame cycle by cycle. p=0 is the boundary cycle (first cycle
  // of digit-0 blank); for the frame after reset there is no pulse and no
  // clock edge before p=0.
  task automatic check_frame(input int f, input logic first, input logic [15:0] nib,
                             input logic [3:0] dark, input logic [3:0] dpm,
                             input ld_t la, input ld_t lb);
    int s;
    logic show;
    logic [15:0] sh;
    logic [3:0] exp_an;
    for (int p = 0; p < 24; p++) begin
      if (!(first && p == 0)) tick();
      s    = p / 6;
      show = (p % 6) >= 2;
      sh   = nib >> (4 * s);
      exp_an = 4'hF;
      if (show && !dark[s]) exp_an[s] = 1'b0;
      chk($sformatf("anode f%0d p%0d", f, p), 32'(anode_l), 32'(exp_an));
      chk($sformatf("seg_en f%0d p%0d", f, p), 32'(seg_en), 32'(show));
      chk($sformatf("bin f%0d p%0d", f, p), 32'(bin_num), 32'(sh[3:0]));
      chk($sformatf("frame_done f%0d p%0d", f, p), 32'(frame_done), 32'(p == 0 && !first));
      if (p > 0) chk($sformatf("dp f%0d p%0d", f, p), 32'(dp_out), 32'(dpm[(p - 1) / 6]));
      if (p == la.p) apply_load(la);
      if (p == lb.p) apply_load(lb);
    end
  endtask

  initial begin
    ld_t a, b;
    rst_n       = 1'b0;
    bus.i_Load  = 1'b0;
    bus.i_Value = 16'h0;
    bus.i_DP    = 4'h0;
    bus.i_Blank = 4'h0;
    bus.i_LZ_En = 1'b0;

    // Reset values held across clock edges
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst anode", 32'(anode_l), 32'hF);
    chk("rst bin", 32'(bin_num), 32'h0);
    chk("rst seg_en", 32'(seg_en), 32'h0);
    chk("rst dp", 32'(dp_out), 32'h0);
    chk("rst frame_done", 32'(frame_done), 32'h0);

    // Frame 0: nothing loaded, zeros shown; two loads, last one wins
    rst_n = 1'b1;
    a = '{p: 10, v: 16'h5555, dp: 4'h0, bl: 4'h0, lz: 1'b0};
    b = '{p: 15, v: 16'h12AB, dp: 4'h0, bl: 4'h0, lz: 1'b0};
    check_frame(0, 1'b1, 16'h0000, 4'b0000, 4'b0000, a, b);

    // Frame 1: B,A,2,1; queue 0040 with leading-zero suppression
    a = '{p: 5, v: 16'h0040, dp: 4'h0, bl: 4'h0, lz: 1'b1};
    check_frame(1, 1'b0, 16'h12AB, 4'b0000, 4'b0000, a, NO_LD);

    // Frame 2: digits 3,2 suppressed; 1111 queued, 2222 loaded on boundary cycle
    a = '{p: 10, v: 16'h1111, dp: 4'h0, bl: 4'h0, lz: 1'b1};
    b = '{p: 23, v: 16'h2222, dp: 4'h0, bl: 4'h0, lz: 1'b1};
    check_frame(2, 1'b0, 16'h0040, 4'b1100, 4'b0000, a, b);

    // Frame 3: 1111, frame 4: 2222
    check_frame(3, 1'b0, 16'h1111, 4'b0000, 4'b0000, NO_LD, NO_LD);
    a = '{p: 5, v: 16'h3210, dp: 4'b0010, bl: 4'b0101, lz: 1'b0};
    check_frame(4, 1'b0, 16'h2222, 4'b0000, 4'b0000, a, NO_LD);

    // Frame 5: digits 0 and 2 forced dark, DP on digit 1 only
    a = '{p: 5, v: 16'h0000, dp: 4'h0, bl: 4'h0, lz: 1'b0};
    check_frame(5, 1'b0, 16'h3210, 4'b0101, 4'b0010, a, NO_LD);

    // Frame 6: advance into digit-2 show, then reset asynchronously
    for (int i = 0; i < 16; i++) tick();
    chk("pre-rst anode", 32'(anode_l), 32'b1011);
    chk("pre-rst seg_en", 32'(seg_en), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst anode", 32'(anode_l), 32'hF);
    chk("async rst seg_en", 32'(seg_en), 32'h0);
    chk("async rst bin", 32'(bin_num), 32'h0);
    chk("async rst frame_done", 32'(frame_done), 32'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("held rst anode", 32'(anode_l), 32'hF);

    // After release scanning restarts at digit 0
    rst_n = 1'b1;
    check_frame(7, 1'b1, 16'h0000, 4'b0000, 4'b0000, NO_LD, NO_LD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
